reg_hazard_ctrl: RTL and testbench

REG_HAZARD_CTRL -- requirements
Module: reg_hazard_ctrl

---
 rtl/reg_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_reg_hazard_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_hazard_ctrl.sv
// reg_hazard_ctrl
//
// Register-hazard controller for a five-stage pipeline. It tracks the
// destination of every in-flight instruction in three slots (E, M, W),
// forwards the youngest producer's value to the D-stage operands, raises
// stall when a producer cannot deliver its result before the consumer needs
// it, and drives the register-file write port from the W slot.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   d_rs, d_rt            D-stage source register numbers
//   d_tuse_rs, d_tuse_rt  cycles until D needs each operand (0..2)
//   d_rd1, d_rd2          raw register-file read data for d_rs / d_rt
//   d_wr, d_wa, d_tnew    D instruction write enable, destination, latency
//   d_pc                  D instruction PC
//   e_result              E-stage ALU result (valid when E tnew == 0)
//   m_load                M-stage memory read data
//   stall                 hold F/D and insert a bubble into E
//   rs_val, rt_val        forwarded D-stage operands
//   rs_ready, rt_ready    forwarded operand is final
//   w_we, w_wa, w_wd, w_pc register-file write port (from the W slot)

module reg_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [31:0] d_rd1,
  input  logic [31:0] d_rd2,
  input  logic        d_wr,
  input  logic [4:0]  d_wa,
  input  logic [1:0]  d_tnew,
  input  logic [31:0] d_pc,
  input  logic [31:0] e_result,
  input  logic [31:0] m_load,
  output logic        stall,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic        rs_ready,
  output logic        rt_ready,
  output logic        w_we,
  output logic [4:0]  w_wa,
  output logic [31:0] w_wd,
  output logic [31:0] w_pc
);

  // E slot
  logic        e_valid_q, e_valid_d;
  logic        e_wr_q,    e_wr_d;
  logic [4:0]  e_wa_q,    e_wa_d;
  logic [1:0]  e_tnew_q,  e_tnew_d;
  logic [31:0] e_pc_q,    e_pc_d;

  // M slot
  logic        m_valid_q, m_valid_d;
  logic        m_wr_q,    m_wr_d;
  logic [4:0]  m_wa_q,    m_wa_d;
  logic [1:0]  m_tnew_q,  m_tnew_d;
  logic [31:0] m_pc_q,    m_pc_d;
  logic [31:0] m_data_q,  m_data_d;

  // W slot
  logic        w_valid_q, w_valid_d;
  logic        w_wr_q,    w_wr_d;
  logic [4:0]  w_wa_q,    w_wa_d;
  logic [1:0]  w_tnew_q,  w_tnew_d;
  logic [31:0] w_pc_q,    w_pc_d;
  logic [31:0] w_data_q,  w_data_d;

  typedef struct packed {
    logic [31:0] val;
    logic [1:0]  tnew;
  } fwd_t;

  fwd_t rs_fwd, rt_fwd;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Youngest matching producer wins. tnew of the winner is returned so the
  // caller can derive both readiness and the stall condition; no match
  // reports tnew 0, which is always ready and never stalls.
  function automatic fwd_t resolve(input logic [4:0] r, input logic [31:0] rd);
    fwd_t f;
    f.val  = rd;
    f.tnew = 2'd0;
    if (r == 5'd0) begin
      f.val = 32'd0;
    end else if (e_valid_q && e_wr_q && (e_wa_q == r)) begin
      f.val  = e_result;
      f.tnew = e_tnew_q;
    end else if (m_valid_q && m_wr_q && (m_wa_q == r)) begin
      f.val  = m_data_q;
      f.tnew = m_tnew_q;
    end else if (w_valid_q && w_wr_q && (w_wa_q == r)) begin
      f.val  = w_data_q;
      f.tnew = w_tnew_q;
    end
    return f;
  endfunction

  always_comb begin
    rs_fwd = resolve(d_rs, d_rd1);
    rt_fwd = resolve(d_rt, d_rd2);
  end

  assign rs_val   = rs_fwd.val;
  assign rt_val   = rt_fwd.val;
  assign rs_ready = (rs_fwd.tnew == 2'd0);
  assign rt_ready = (rt_fwd.tnew == 2'd0);
  assign stall    = (rs_fwd.tnew > d_tuse_rs) || (rt_fwd.tnew > d_tuse_rt);

  // Next-state: E takes the D instruction or a bubble; M and W always
  // advance, even while stalled, so the producer keeps moving toward W.
  always_comb begin
    if (stall) begin
      e_valid_d = 1'b0;
      e_wr_d    = 1'b0;
      e_wa_d    = 5'd0;
      e_tnew_d  = 2'd0;
      e_pc_d    = 32'd0;
    end else begin
      e_valid_d = 1'b1;
      e_wr_d    = d_wr;
      e_wa_d    = d_wa;
      e_tnew_d  = d_tnew;
      e_pc_d    = d_pc;
    end

    m_valid_d = e_valid_q;
    m_wr_d    = e_wr_q;
    m_wa_d    = e_wa_q;
    m_tnew_d  = dec_sat(e_tnew_q);
    m_pc_d    = e_pc_q;
    m_data_d  = e_result;

    w_valid_d = m_valid_q;
    w_wr_d    = m_wr_q;
    w_wa_d    = m_wa_q;
    w_tnew_d  = dec_sat(m_tnew_q);
    w_pc_d    = m_pc_q;
    // A producer still pending in M is a load; its result is the memory data.
    w_data_d  = (m_tnew_q == 2'd0) ? m_data_q : m_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q <= 1'b0;
      e_wr_q    <= 1'b0;
      e_wa_q    <= 5'd0;
      e_tnew_q  <= 2'd0;
      e_pc_q    <= 32'd0;
      m_valid_q <= 1'b0;
      m_wr_q    <= 1'b0;
      m_wa_q    <= 5'd0;
      m_tnew_q  <= 2'd0;
      m_pc_q    <= 32'd0;
      m_data_q  <= 32'd0;
      w_valid_q <= 1'b0;
      w_wr_q    <= 1'b0;
      w_wa_q    <= 5'd0;
      w_tnew_q  <= 2'd0;
      w_pc_q    <= 32'd0;
      w_data_q  <= 32'd0;
    end else begin
      e_valid_q <= e_valid_d;
      e_wr_q    <= e_wr_d;
      e_wa_q    <= e_wa_d;
      e_tnew_q  <= e_tnew_d;
      e_pc_q    <= e_pc_d;
      m_valid_q <= m_valid_d;
      m_wr_q    <= m_wr_d;
      m_wa_q    <= m_wa_d;
      m_tnew_q  <= m_tnew_d;
      m_pc_q    <= m_pc_d;
      m_data_q  <= m_data_d;
      w_valid_q <= w_valid_d;
      w_wr_q    <= w_wr_d;
      w_wa_q    <= w_wa_d;
      w_tnew_q  <= w_tnew_d;
      w_pc_q    <= w_pc_d;
      w_data_q  <= w_data_d;
    end
  end

  assign w_we = w_valid_q && w_wr_q && (w_wa_q != 5'd0);
  assign w_wa = w_wa_q;
  assign w_wd = w_data_q;
  assign w_pc = w_pc_q;

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Bench for reg_hazard_ctrl: a hand-computed vector table, hand-written
// multi-cycle sequences (long stall, reset during stall, priority, write
// port timing) and randomized stimulus against an instruction-history model.

module tb_reg_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic [31:0] d_rd1, d_rd2, d_pc, e_result, m_load;
  logic        d_wr;
  logic        stall, rs_ready, rt_ready, w_we;
  logic [31:0] rs_val, rt_val, w_wd, w_pc;
  logic [4:0]  w_wa;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_rd1     (d_rd1),
    .d_rd2     (d_rd2),
    .d_wr      (d_wr),
    .d_wa      (d_wa),
    .d_tnew    (d_tnew),
    .d_pc      (d_pc),
    .e_result  (e_result),
    .m_load    (m_load),
    .stall     (stall),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .rs_ready  (rs_ready),
    .rt_ready  (rt_ready),
    .w_we      (w_we),
    .w_wa      (w_wa),
    .w_wd      (w_wd),
    .w_pc      (w_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic wr, input logic [4:0] wa, input logic [1:0] tnew,
                       input logic [31:0] pc, input logic [31:0] er, input logic [31:0] ml);
    d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
    d_rd1 = rd1; d_rd2 = rd2; d_wr = wr; d_wa = wa; d_tnew = tnew;
    d_pc = pc; e_result = er; m_load = ml;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  rs, rt;
    logic [1:0]  tu_rs, tu_rt;
    logic [31:0] rd1, rd2;
    logic        wr;
    logic [4:0]  wa;
    logic [1:0]  tnew;
    logic [31:0] pc, er, ml;
    logic        x_stall;
    logic [31:0] x_rs, x_rt;
    logic        x_rsr, x_rtr, x_we;
    logic [4:0]  x_wa;
    logic [31:0] x_wd, x_wpc;
  } vec_t;

  vec_t vecs[12];

  // ---------------- reference model ----------------
  // hist[a] is the instruction issued a cycles ago (0 = in E, 1 = M, 2 = W),
  // with the E result and memory data it saw on its way through.
  typedef struct {
    logic        valid, wr;
    logic [4:0]  wa;
    logic [1:0]  tnew;
    logic [31:0] pc, e_res, m_ld;
  } inst_t;

  inst_t hist[3];

  function automatic int remaining(int a);
    int t;
    t = int'(hist[a].tnew) - a;
    return (t > 0) ? t : 0;
  endfunction

  function automatic logic [31:0] value_at(int a);
    if (a == 0) return e_result;
    if (a == 1) return hist[1].e_res;
    // Anything still pending after E was a load and took memory data.
    return (hist[2].tnew <= 2'd1) ? hist[2].e_res : hist[2].m_ld;
  endfunction

  task automatic model_operand(input logic [4:0] r, input logic [31:0] rd,
                               output logic [31:0] val, output int tn);
    bit found = 0;
    val = rd;
    tn  = 0;
    if (r == 5'd0) begin
      val = 32'd0;
    end else begin
      for (int a = 0; a < 3; a++) begin
        if (!found && hist[a].valid && hist[a].wr && hist[a].wa == r) begin
          found = 1;
          val   = value_at(a);
          tn    = remaining(a);
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 3; a++) hist[a] = '{default: '0};
  endtask

  task automatic model_advance(input bit stalled);
    hist[0].e_res = e_result;
    hist[1].m_ld  = m_load;
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (stalled) hist[0] = '{default: '0};
    else hist[0] = '{1'b1, d_wr, d_wa, d_tnew, d_pc, 32'd0, 32'd0};
  endtask

  initial begin
    vec_t v;
    logic [31:0] m_rs, m_rt;
    int t_rs, t_rt;
    bit m_stall;
    logic m_we;

    // rs rt turs turt rd1 rd2 wr wa tnew pc er ml | stall rsv rtv rsr rtr we wa wd wpc
    vecs[0]  = '{0, 0, 0, 0, 32'h11, 32'h22, 1, 8, 0, 32'h3000, 32'h0, 32'h0,
                 0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 32'h0};
    vecs[1]  = '{8, 7, 1, 0, 32'hAAAA, 32'hBBBB, 0, 0, 0, 32'h3004, 32'h1234, 32'h0,
                 0, 32'h1234, 32'hBBBB, 1, 1, 0, 0, 32'h0, 32'h0};
    vecs[2]  = '{8, 8, 0, 0, 32'h1, 32'h2, 1, 9, 1, 32'h3008, 32'h77, 32'h99,
                 0, 32'h1234, 32'h1234, 1, 1, 0, 0, 32'h0, 32'h0};
    vecs[3]  = '{9, 8, 0, 0, 32'h5, 32'h6, 0, 0, 0, 32'h300C, 32'hCAFE, 32'hCAFE,
                 1, 32'h0, 32'h1234, 0, 1, 1, 8, 32'h1234, 32'h3000};
    vecs[4]  = '{9, 8, 0, 0, 32'h5, 32'h6, 0, 0, 0, 32'h300C, 32'h5, 32'h6,
                 0, 32'hCAFE, 32'h6, 1, 1, 0, 0, 32'h77, 32'h3004};
    vecs[5]  = '{0, 9, 2, 2, 32'h123, 32'h456, 1, 0, 0, 32'h3010, 32'hFFFF, 32'h0,
                 0, 32'h0, 32'hCAFE, 1, 1, 1, 9, 32'hCAFE, 32'h3008};
    vecs[6]  = '{0, 0, 0, 0, 32'h1, 32'h2, 1, 3, 0, 32'h3014, 32'h10, 32'h0,
                 0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h5, 32'h0};
    vecs[7]  = '{0, 0, 0, 0, 32'h1, 32'h2, 1, 3, 1, 32'h3018, 32'h20, 32'h21,
                 0, 32'h0, 32'h0, 1, 1, 0, 0, 32'hFFFF, 32'h300C};
    vecs[8]  = '{3, 3, 2, 1, 32'h1, 32'h2, 1, 3, 2, 32'h301C, 32'h30, 32'h31,
                 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h10, 32'h3010};
    vecs[9]  = '{3, 3, 2, 2, 32'hAA, 32'hBB, 0, 0, 0, 32'h3020, 32'h40, 32'h41,
                 0, 32'h0, 32'h0, 0, 0, 1, 3, 32'h20, 32'h3014};
    vecs[10] = '{3, 5, 1, 0, 32'h1, 32'h5555, 0, 0, 0, 32'h3024, 32'h50, 32'h51,
                 0, 32'h0, 32'h5555, 0, 1, 1, 3, 32'h30, 32'h3018};
    vecs[11] = '{3, 3, 0, 0, 32'h1, 32'h2, 0, 0, 0, 32'h3028, 32'h60, 32'h61,
                 0, 32'h51, 32'h51, 1, 1, 1, 3, 32'h51, 32'h301C};

    // Reset state: empty slots, operands pass through, zero for register 0.
    reset = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    set_d(6, 0, 0, 0, 32'h1357, 32'h2468, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst stall", 32'(stall), 0);
    chk("rst w_we", 32'(w_we), 0);
    chk("rst rs_ready", 32'(rs_ready), 1);
    chk("rst rt_ready", 32'(rt_ready), 1);
    chk("rst rs_val", rs_val, 32'h1357);
    chk("rst rt_val r0", rt_val, 32'h0);

    // Table vectors, applied back to back from a clean reset.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      set_d(v.rs, v.rt, v.tu_rs, v.tu_rt, v.rd1, v.rd2, v.wr, v.wa, v.tnew, v.pc, v.er, v.ml);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(v.x_stall));
      chk($sformatf("v%0d rs_ready", i), 32'(rs_ready), 32'(v.x_rsr));
      chk($sformatf("v%0d rt_ready", i), 32'(rt_ready), 32'(v.x_rtr));
      if (v.x_rsr) chk($sformatf("v%0d rs_val", i), rs_val, v.x_rs);
      if (v.x_rtr) chk($sformatf("v%0d rt_val", i), rt_val, v.x_rt);
      chk($sformatf("v%0d w_we", i), 32'(w_we), 32'(v.x_we));
      chk($sformatf("v%0d w_wa", i), 32'(w_wa), 32'(v.x_wa));
      chk($sformatf("v%0d w_wd", i), w_wd, v.x_wd);
      chk($sformatf("v%0d w_pc", i), w_pc, v.x_wpc);
      step();
    end

    // Two-cycle stall: tnew=2 producer, tuse=0 consumer; load data forwarded.
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 1, 4, 2, 32'h4000, 0, 0);
    @(negedge clk);
    chk("ws issue stall", 32'(stall), 0);
    step();
    set_d(4, 0, 0, 0, 32'hDEAD, 0, 0, 0, 0, 32'h4004, 32'h100, 0);
    @(negedge clk);
    chk("ws stall1", 32'(stall), 1);
    chk("ws rs_ready1", 32'(rs_ready), 0);
    step();
    m_load = 32'hBEEF;
    @(negedge clk);
    chk("ws stall2", 32'(stall), 1);
    step();
    @(negedge clk);
    chk("ws stall3", 32'(stall), 0);
    chk("ws rs_val", rs_val, 32'hBEEF);
    chk("ws rs_ready", 32'(rs_ready), 1);
    chk("ws w_we", 32'(w_we), 1);
    chk("ws w_wa", 32'(w_wa), 4);
    chk("ws w_wd", w_wd, 32'hBEEF);
    chk("ws w_pc", w_pc, 32'h4000);
    step();

    // Reset in the middle of a stall discards the pending writer.
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 1, 4, 2, 32'h4100, 0, 0);
    step();
    set_d(4, 0, 0, 0, 32'hD00D, 32'h9, 0, 0, 0, 32'h4104, 32'h200, 32'h300);
    @(negedge clk);
    chk("rs stall before", 32'(stall), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rs c%0d stall", c), 32'(stall), 0);
      chk($sformatf("rs c%0d w_we", c), 32'(w_we), 0);
      chk($sformatf("rs c%0d rs_ready", c), 32'(rs_ready), 1);
      chk($sformatf("rs c%0d rs_val", c), rs_val, 32'hD00D);
      step();
    end

    // E, M and W all writing r3 with distinct data: E wins on both operands.
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 1, 3, 0, 32'h5000, 32'h0, 0);
    step();
    set_d(0, 0, 0, 0, 0, 0, 1, 3, 0, 32'h5004, 32'hA1, 0);
    step();
    set_d(0, 0, 0, 0, 0, 0, 1, 3, 0, 32'h5008, 32'hA2, 0);
    step();
    set_d(3, 3, 0, 0, 32'h11, 32'h22, 0, 0, 0, 32'h500C, 32'hA3, 0);
    @(negedge clk);
    chk("pri rs_val", rs_val, 32'hA3);
    chk("pri rt_val", rt_val, 32'hA3);
    chk("pri stall", 32'(stall), 0);
    chk("pri w_wd", w_wd, 32'hA1);
    step();

    // Write port timing: writer data appears on W three clocks after issue.
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 1, 5, 0, 32'h3004, 0, 0);
    step();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 32'h55, 0);
    step();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300C, 32'h66, 0);
    step();
    set_d(5, 0, 0, 0, 32'hDEAD, 0, 0, 0, 0, 32'h3010, 32'h77, 0);
    @(negedge clk);
    chk("wp w_we", 32'(w_we), 1);
    chk("wp w_wa", 32'(w_wa), 5);
    chk("wp w_wd", w_wd, 32'h55);
    chk("wp w_pc", w_pc, 32'h3004);
    chk("wp rs_val", rs_val, 32'h55);
    step();

    // Randomized run against the history model.
    do_reset();
    model_clear();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      set_d(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
            $urandom, $urandom, ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
            $urandom, $urandom, $urandom);
      @(negedge clk);
      model_operand(d_rs, d_rd1, m_rs, t_rs);
      model_operand(d_rt, d_rd2, m_rt, t_rt);
      m_stall = (t_rs > int'(d_tuse_rs)) || (t_rt > int'(d_tuse_rt));
      m_we = hist[2].valid && hist[2].wr && (hist[2].wa != 5'd0);
      chk($sformatf("r%0d stall", i), 32'(stall), 32'(m_stall));
      chk($sformatf("r%0d rs_ready", i), 32'(rs_ready), 32'(t_rs == 0));
      chk($sformatf("r%0d rt_ready", i), 32'(rt_ready), 32'(t_rt == 0));
      if (t_rs == 0) chk($sformatf("r%0d rs_val", i), rs_val, m_rs);
      if (t_rt == 0) chk($sformatf("r%0d rt_val", i), rt_val, m_rt);
      chk($sformatf("r%0d w_we", i), 32'(w_we), 32'(m_we));
      chk($sformatf("r%0d w_wa", i), 32'(w_wa), 32'(hist[2].wa));
      chk($sformatf("r%0d w_wd", i), w_wd, value_at(2));
      chk($sformatf("r%0d w_pc", i), w_pc, hist[2].pc);
      if (reset) model_clear();
      else model_advance(m_stall);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
